// File: rtl/debayer_nx.sv
// 2x2-window Bayer demosaic with one line buffer, runtime CFA phase, valid/ready
// backpressure, frame-aligned geometry shadowing and SOF/EOL sidebands.
module debayer_nx #(
  parameter int          W       = 1920,
  parameter int          H       = 1080,
  parameter int          DEPTH   = 8,
  parameter int          MAX_W   = 4096,
  parameter logic [1:0]  PATTERN = 2'b00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DEPTH-1:0]     sink_data,
  input  logic                 sink_valid,
  output logic                 sink_ready,
  output logic [3*DEPTH-1:0]   source_data,
  output logic                 source_valid,
  input  logic                 source_ready,
  output logic                 source_sof,
  output logic                 source_eol,
  input  logic [35:0]          control_in_data,
  input  logic                 control_in_valid,
  output logic [35:0]          control_out_data,
  output logic                 control_out_valid
);

  localparam int          AW      = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [16:0] MAX_W_C = 17'(MAX_W);

  logic [15:0] x, y;
  logic [15:0] act_w, act_h, pend_w, pend_h;
  logic [1:0]  act_p, pend_p;
  logic [15:0] cur_w, cur_h;
  logic [1:0]  cur_p;

  logic [DEPTH-1:0] line_mem [MAX_W];
  logic [DEPTH-1:0] above_p0, left_p0, above_left_p0;
  logic [3*DEPTH-1:0] rgb_p0;
  logic accept, at_origin, last_x, x_par, y_par;

  function automatic logic [DEPTH-1:0] avg2(input logic [DEPTH-1:0] a,
                                            input logic [DEPTH-1:0] b);
    logic [DEPTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEPTH:1];
  endfunction

  function automatic logic [15:0] clamp_w(input logic [15:0] w);
    if ({1'b0, w} > MAX_W_C) return MAX_W_C[15:0];
    return w;
  endfunction

  assign sink_ready = ~source_valid | source_ready;
  assign accept     = sink_valid & sink_ready;
  assign at_origin  = (x == 16'd0) && (y == 16'd0);

  // The first sample of a frame already sees the geometry it is about to latch.
  assign cur_w  = at_origin ? pend_w : act_w;
  assign cur_h  = at_origin ? pend_h : act_h;
  assign cur_p  = at_origin ? pend_p : act_p;
  assign last_x = (x == cur_w - 16'd1);

  assign above_p0 = line_mem[x[AW-1:0]];
  assign x_par    = x[0] ^ cur_p[0];
  assign y_par    = y[0] ^ cur_p[1];

  // ---- stage 0: window classification and colour reconstruction ----
  always_comb begin
    rgb_p0 = {3{sink_data}};
    if (x != 16'd0 && y != 16'd0) begin
      unique case ({y_par, x_par})
        2'b00: rgb_p0 = {sink_data, avg2(above_p0, left_p0), above_left_p0};
        2'b11: rgb_p0 = {above_left_p0, avg2(above_p0, left_p0), sink_data};
        2'b01: rgb_p0 = {left_p0, avg2(sink_data, above_left_p0), above_p0};
        default: rgb_p0 = {above_p0, avg2(sink_data, above_left_p0), left_p0};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) line_mem[x[AW-1:0]] <= sink_data;
  end

  // ---- stage 1: output register, counters and geometry shadowing ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x                 <= '0;
      y                 <= '0;
      act_w             <= 16'(W);
      act_h             <= 16'(H);
      act_p             <= PATTERN;
      pend_w            <= 16'(W);
      pend_h            <= 16'(H);
      pend_p            <= PATTERN;
      left_p0           <= '0;
      above_left_p0     <= '0;
      source_valid      <= 1'b0;
      source_data       <= '0;
      source_sof        <= 1'b0;
      source_eol        <= 1'b0;
      control_out_valid <= 1'b0;
      control_out_data  <= '0;
    end else begin
      control_out_valid <= control_in_valid;
      control_out_data  <= control_in_data;
      if (control_in_valid) begin
        if (control_in_data[35:20] != 16'd0) pend_w <= clamp_w(control_in_data[35:20]);
        if (control_in_data[19:4] != 16'd0)  pend_h <= control_in_data[19:4];
        pend_p <= control_in_data[1:0];
      end
      if (accept) begin
        if (at_origin) begin
          act_w <= pend_w;
          act_h <= pend_h;
          act_p <= pend_p;
        end
        left_p0       <= sink_data;
        above_left_p0 <= above_p0;
        if (last_x) begin
          x <= '0;
          y <= (y == cur_h - 16'd1) ? 16'd0 : y + 16'd1;
        end else begin
          x <= x + 16'd1;
        end
        source_valid <= 1'b1;
        source_data  <= rgb_p0;
        source_sof   <= at_origin;
        source_eol   <= last_x;
      end else if (source_ready) begin
        source_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debayer_nx.sv
// Bench for debayer_nx: directed spec cases plus randomized frames checked
// against a frame-array reference model.
module tb_debayer_nx;
  localparam int         W = 4, H = 2, DEPTH = 8, MAX_W = 16;
  localparam logic [1:0] PAT = 2'b00;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  sink_data = '0;
  logic        sink_valid = 1'b0, sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_ready = 1'b1, source_sof, source_eol;
  logic [35:0] control_in_data = '0, control_out_data;
  logic        control_in_valid = 1'b0, control_out_valid;

  always #5 clk = ~clk;

  debayer_nx #(.W(W), .H(H), .DEPTH(DEPTH), .MAX_W(MAX_W), .PATTERN(PAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sof(source_sof), .source_eol(source_eol),
    .control_in_data(control_in_data), .control_in_valid(control_in_valid),
    .control_out_data(control_out_data), .control_out_valid(control_out_valid)
  );

  typedef struct packed { logic [23:0] d; logic sof; logic eol; } pix_t;
  pix_t exp_q[$];
  pix_t got_q[$];
  int total = 0, bad = 0;
  bit bp_en = 0, gap_en = 0;

  int mx, my, aw, ah, pw, ph;
  logic [1:0] ap, pp;
  int img [0:63][0:15];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // 0 = red, 1 = green, 2 = blue
  function automatic int site(input int sx, input int sy, input logic [1:0] p);
    bit xm, ym;
    xm = ((sx % 2) == int'(p[0]));
    ym = ((sy % 2) == int'(p[1]));
    if (xm && ym) return 0;
    if (!xm && !ym) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0;
    aw = W; ah = H; ap = PAT;
    pw = W; ph = H; pp = PAT;
    exp_q.delete();
  endtask

  task automatic model_ctrl(input logic [35:0] c);
    if (c[35:20] != 0) pw = (int'(c[35:20]) > MAX_W) ? MAX_W : int'(c[35:20]);
    if (c[19:4] != 0)  ph = int'(c[19:4]);
    pp = c[1:0];
  endtask

  task automatic model_accept(input int s);
    pix_t e;
    int r, g, b, v;
    if (mx == 0 && my == 0) begin aw = pw; ah = ph; ap = pp; end
    img[my][mx] = s;
    if (mx == 0 || my == 0) begin
      r = s; g = s; b = s;
    end else begin
      r = 0; g = 0; b = 0;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          v = img[my-1+dy][mx-1+dx];
          case (site(mx-1+dx, my-1+dy, ap))
            0: r = v;
            2: b = v;
            default: g += v;
          endcase
        end
      g = g / 2;
    end
    e.d = {8'(r), 8'(g), 8'(b)};
    e.sof = (mx == 0 && my == 0);
    e.eol = (mx == aw - 1);
    exp_q.push_back(e);
    if (mx == aw - 1) begin
      mx = 0;
      my = (my == ah - 1) ? 0 : my + 1;
    end else mx++;
  endtask

  task automatic step(output bit acc);
    bit cons, rs, cv;
    logic [35:0] cd;
    logic [7:0] sd;
    #1;
    rs = rst_n;
    acc = rs && sink_valid && sink_ready;
    cons = rs && source_valid && source_ready;
    cv = control_in_valid; cd = control_in_data; sd = sink_data;
    if (cons) got_q.push_back(pix_t'({source_data, source_sof, source_eol}));
    @(posedge clk); #1;
    if (!rs) model_reset();
    else begin
      if (cons && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) model_accept(int'(sd));
      if (cv) model_ctrl(cd);
    end
    chk("source_valid", source_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("source_data", source_data, exp_q[0].d);
      chk("source_sof", source_sof, exp_q[0].sof);
      chk("source_eol", source_eol, exp_q[0].eol);
    end
    chk("ctrl_valid", control_out_valid, rs ? cv : 1'b0);
    if (rs && cv) chk("ctrl_data", control_out_data, cd);
    chk("sink_ready", sink_ready, !source_valid || source_ready);
  endtask

  task automatic send_px(input int v);
    bit a;
    int n;
    sink_data = 8'(v); sink_valid = 1'b1; n = 0;
    do begin
      if (bp_en) source_ready = ($urandom_range(0, 3) != 0);
      step(a);
      n++;
    end while (!a && n < 64);
    chk("accept_timeout", a, 1'b1);
    sink_valid = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) step(a);
  endtask

  task automatic send_ctrl(input int w, input int h, input logic [1:0] p);
    bit a;
    control_in_data = {16'(w), 16'(h), 2'b00, p};
    control_in_valid = 1'b1;
    step(a);
    control_in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int n;
    sink_valid = 1'b0; source_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 64) begin step(a); n++; end
    step(a);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_basic(input string tag);
    int br[8] = '{10, 20, 30, 40, 50, 10, 30, 30};
    int bg[8] = '{10, 20, 30, 40, 50, 35, 45, 55};
    int bb[8] = '{10, 20, 30, 40, 50, 60, 60, 80};
    chk({tag, "_count"}, got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      chk({tag, "_rgb"}, got_q[i].d, {8'(br[i]), 8'(bg[i]), 8'(bb[i])});
      chk({tag, "_sof"}, got_q[i].sof, i == 0);
      chk({tag, "_eol"}, got_q[i].eol, i == 3 || i == 7);
    end
  endtask

  initial begin
    int fr[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
    bit a;
    int n;
    logic [23:0] held;
    model_reset();

    // reset state
    step(a); step(a);
    chk("rst_data", source_data, 0);
    chk("rst_sof", source_sof, 0);
    chk("rst_eol", source_eol, 0);
    chk("rst_ctrl_data", control_out_data, 0);
    rst_n = 1'b1;

    // basic 4x2 RGGB frame
    send_ctrl(4, 2, 2'b00);
    got_q.delete();
    foreach (fr[i]) send_px(fr[i]);
    drain();
    check_basic("basic");

    // BGGR phase
    send_ctrl(4, 2, 2'b11);
    got_q.delete();
    foreach (fr[i]) send_px(fr[i]);
    drain();
    chk("bggr_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      chk("bggr_x1", got_q[5].d, {8'd60, 8'd35, 8'd10});
      chk("bggr_x3", got_q[7].d, {8'd80, 8'd55, 8'd30});
    end

    // backpressure for three cycles mid-row
    send_ctrl(4, 2, 2'b00);
    got_q.delete();
    send_px(10); send_px(20);
    source_ready = 1'b0; sink_data = 8'd30; sink_valid = 1'b1;
    held = source_data;
    repeat (3) begin
      step(a);
      chk("bp_no_accept", a, 0);
      chk("bp_sink_ready", sink_ready, 0);
      chk("bp_hold", source_data, held);
    end
    source_ready = 1'b1; sink_valid = 1'b0;
    for (int i = 2; i < 8; i++) send_px(fr[i]);
    drain();
    check_basic("bp");

    // control packet mid-frame takes effect next frame
    got_q.delete();
    for (int i = 0; i < 3; i++) send_px(fr[i]);
    send_ctrl(2, 2, 2'b00);
    for (int i = 3; i < 8; i++) send_px(fr[i]);
    for (int i = 0; i < 4; i++) send_px(fr[i]);
    drain();
    chk("mid_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      chk("mid_eol", got_q[i].eol, i == 3 || i == 7 || i == 9 || i == 11);
      chk("mid_sof", got_q[i].sof, i == 0 || i == 8);
    end

    // packet coincident with the (0,0) accept applies from the next frame
    got_q.delete();
    sink_data = 8'd10; sink_valid = 1'b1; source_ready = 1'b1;
    control_in_data = {16'd4, 16'd2, 2'b00, 2'b00}; control_in_valid = 1'b1;
    step(a);
    chk("simul_accept", a, 1);
    control_in_valid = 1'b0; sink_valid = 1'b0;
    for (int i = 1; i < 4; i++) send_px(fr[i]);
    foreach (fr[i]) send_px(fr[i]);
    drain();
    chk("simul_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk("simul_eol", got_q[i].eol, i == 1 || i == 3 || i == 7 || i == 11);

    // green averaging at full scale
    send_ctrl(2, 2, 2'b00);
    got_q.delete();
    send_px(7); send_px(255); send_px(254); send_px(9);
    drain();
    chk("green_count", got_q.size(), 4);
    if (got_q.size() == 4) chk("green_avg", got_q[3].d, {8'd7, 8'd254, 8'd9});

    // width beyond line buffer clamps to MAX_W
    send_ctrl(100, 1, 2'b00);
    got_q.delete();
    for (int i = 0; i < MAX_W; i++) send_px(i + 1);
    drain();
    chk("clamp_count", got_q.size(), MAX_W);
    if (got_q.size() == MAX_W) begin
      chk("clamp_eol_last", got_q[MAX_W-1].eol, 1);
      chk("clamp_eol_prev", got_q[MAX_W-2].eol, 0);
      chk("clamp_sof", got_q[0].sof, 1);
    end

    // randomized frames with backpressure, gaps and stray control packets
    bp_en = 1; gap_en = 1;
    for (int f = 0; f < 8; f++) begin
      send_ctrl(($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 40)
                                            : $urandom_range(1, 16),
                ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4),
                2'($urandom_range(0, 3)));
      n = pw * ph;
      for (int i = 0; i < n; i++) begin
        if (i == n / 2 && $urandom_range(0, 2) == 0)
          send_ctrl($urandom_range(1, 16), $urandom_range(1, 4), 2'($urandom_range(0, 3)));
        send_px($urandom_range(0, 255));
      end
    end
    bp_en = 0; gap_en = 0;
    drain();

    // reset pulse mid-line
    send_ctrl(6, 3, 2'b01);
    send_px(1); send_px(2);
    rst_n = 1'b0;
    step(a);
    chk("rst_mid_valid", source_valid, 0);
    rst_n = 1'b1;
    got_q.delete();
    foreach (fr[i]) send_px(fr[i]);
    drain();
    check_basic("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
